// File: rtl/qspi_flash_model_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : qspi_flash_model_pkg                                          |
// | Purpose  : Shared opcodes, address width and FSM state type for the      |
// |            QSPI serial-flash behavioural model.                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package qspi_flash_model_pkg;

  localparam int ADDR_W = 24;

  localparam logic [7:0] OP_READ       = 8'h03;
  localparam logic [7:0] OP_QUAD_READ  = 8'hEB;
  localparam logic [7:0] OP_POWER_DOWN = 8'hB9;
  localparam logic [7:0] OP_RELEASE_PD = 8'hAB;

  // Mode-byte upper nibble that arms continuous read
  localparam logic [3:0] CRM_NIBBLE    = 4'hA;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    MODE   = 3'd3,
    DUMMY  = 3'd4,
    DATA   = 3'd5,
    IGNORE = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/qspi_flash_model_sclk_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : qspi_sclk_sync                                                |
// | Purpose  : Two-flop synchronisers for host SCLK and CS#, plus SCLK edge  |
// |            detection on the synchronised samples.                        |
// | Ports    : clk_1x, reset_n      - oversampling clock, async low reset    |
// |            flash_clk, flash_csn - raw host SCLK / CS#                    |
// |            rise, fall           - single-cycle SCLK edge strobes         |
// |            csn_sync             - synchronised CS#                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module qspi_sclk_sync (
  input  logic clk_1x,
  input  logic reset_n,
  input  logic flash_clk,
  input  logic flash_csn,
  output logic rise,
  output logic fall,
  output logic csn_sync
);

  // [1:0] is the synchroniser, [2] holds the previous synchronised sample
  logic [2:0] r_sclk_pipe;
  logic [1:0] r_csn_pipe;

  always_ff @(posedge clk_1x or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk_pipe <= 3'b000;
      r_csn_pipe  <= 2'b11;   // deselected out of reset
    end else begin
      r_sclk_pipe <= {r_sclk_pipe[1:0], flash_clk};
      r_csn_pipe  <= {r_csn_pipe[0], flash_csn};
    end
  end

  assign rise     =  r_sclk_pipe[1] & ~r_sclk_pipe[2];
  assign fall     = ~r_sclk_pipe[1] &  r_sclk_pipe[2];
  assign csn_sync =  r_csn_pipe[1];

endmodule
`default_nettype wire

// File: rtl/qspi_flash_model.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : qspi_flash_model                                              |
// | Purpose  : Behavioural QSPI flash: SPI read (0x03), quad I/O read (0xEB),|
// |            power-down (0xB9) / release (0xAB), side-band preload port.   |
// | Ports    : clk_1x, reset_n         - oversampling clock, async low reset |
// |            flash_clk, flash_csn    - host SCLK and CS#                   |
// |            io_in, io_in_en         - host-driven IO and enables          |
// |            io_out, io_out_en       - model-driven IO and enables         |
// |            load_valid/addr/data/ready - array preload handshake          |
// |            conflict                - both sides driving an IO line       |
// | Options  : QSPI_FLASH_MODEL_CRM_EN enables 0xEB continuous-read mode.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module qspi_flash_model
  import qspi_flash_model_pkg::*;
#(
  parameter int SIZE_BYTES        = 16777216,
  parameter int QUAD_DUMMY_CYCLES = 4
) (
  input  logic              clk_1x,
  input  logic              reset_n,
  input  logic              flash_clk,
  input  logic              flash_csn,
  input  logic [3:0]        io_in,
  input  logic [3:0]        io_in_en,
  output logic [3:0]        io_out,
  output logic [3:0]        io_out_en,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  output logic              conflict
);

  localparam int AW = $clog2(SIZE_BYTES);

  logic       w_rise, w_fall, w_csn_sync;
  state_t     r_state;
  logic [4:0] r_cnt;
  logic [23:0] r_shift;
  logic [AW-1:0] r_addr;
  logic       r_quad, r_pd, r_pd_arm, r_crm, r_rst_done;
  logic [7:0] mem [SIZE_BYTES];

  logic [23:0] w_shift_next;
  logic [7:0]  w_opcode;
  logic [7:0]  w_rd_byte;
  logic [2:0]  w_bit_sel;

  qspi_sclk_sync u_sync (
    .clk_1x    (clk_1x),
    .reset_n   (reset_n),
    .flash_clk (flash_clk),
    .flash_csn (flash_csn),
    .rise      (w_rise),
    .fall      (w_fall),
    .csn_sync  (w_csn_sync)
  );

  assign w_shift_next = r_quad ? {r_shift[19:0], io_in} : {r_shift[22:0], io_in[0]};
  assign w_opcode     = {r_shift[6:0], io_in[0]};
  assign w_rd_byte    = mem[r_addr];
  assign w_bit_sel    = 3'd7 - r_cnt[2:0];

  // Array is not reset so preloaded contents survive reset_n
  always_ff @(posedge clk_1x) begin
    if (load_valid && load_ready)
      mem[load_addr[AW-1:0]] <= load_data;
  end

  always_ff @(posedge clk_1x or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= 5'd0;
      r_shift    <= 24'd0;
      r_addr     <= '0;
      r_quad     <= 1'b0;
      r_pd       <= 1'b0;
      r_pd_arm   <= 1'b0;
      r_crm      <= 1'b0;
      r_rst_done <= 1'b0;
      io_out     <= 4'h0;
      io_out_en  <= 4'h0;
      load_ready <= 1'b0;
      conflict   <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
      conflict   <= |(io_in_en & io_out_en);
      // csn_sync high always returns the FSM to IDLE, so this tracks IDLE
      load_ready <= r_rst_done & w_csn_sync;

      if (w_csn_sync) begin
        r_state   <= IDLE;
        r_cnt     <= 5'd0;
        io_out    <= 4'h0;
        io_out_en <= 4'h0;
        // Power-down takes effect only once the 0xB9 transaction is closed
        if (r_pd_arm)
          r_pd <= 1'b1;
        r_pd_arm  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_cnt   <= 5'd0;
            r_quad  <= r_crm;
            r_state <= r_crm ? ADDR : CMD;
          end

          CMD: if (w_rise) begin
            r_shift <= {r_shift[22:0], io_in[0]};
            r_cnt   <= r_cnt + 5'd1;
            if (r_cnt == 5'd7) begin
              r_cnt <= 5'd0;
              if (r_pd && (w_opcode != OP_RELEASE_PD)) begin
                r_state <= IGNORE;
              end else begin
                case (w_opcode)
                  OP_READ:       begin r_quad <= 1'b0; r_state <= ADDR; end
                  OP_QUAD_READ:  begin r_quad <= 1'b1; r_state <= ADDR; end
                  OP_POWER_DOWN: begin r_pd_arm <= 1'b1; r_state <= IGNORE; end
                  OP_RELEASE_PD: begin r_pd <= 1'b0; r_state <= IGNORE; end
                  default:       r_state <= IGNORE;
                endcase
              end
            end
          end

          ADDR: if (w_rise) begin
            r_shift <= w_shift_next;
            r_cnt   <= r_cnt + 5'd1;
            if (r_cnt == (r_quad ? 5'd5 : 5'd23)) begin
              r_cnt   <= 5'd0;
              r_addr  <= w_shift_next[AW-1:0];
              r_state <= r_quad ? MODE : DATA;
            end
          end

          MODE: if (w_rise) begin
            r_shift <= w_shift_next;
            r_cnt   <= r_cnt + 5'd1;
            if (r_cnt == 5'd1) begin
              r_cnt   <= 5'd0;
`ifdef QSPI_FLASH_MODEL_CRM_EN
              r_crm   <= (w_shift_next[7:4] == CRM_NIBBLE);
`endif
              r_state <= (QUAD_DUMMY_CYCLES == 0) ? DATA : DUMMY;
            end
          end

          DUMMY: if (w_rise) begin
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'(QUAD_DUMMY_CYCLES - 1)) begin
              r_cnt   <= 5'd0;
              r_state <= DATA;
            end
          end

          // Data launches on SCLK fall so the host can sample on the rise
          DATA: if (w_fall) begin
            if (r_quad) begin
              io_out    <= r_cnt[0] ? w_rd_byte[3:0] : w_rd_byte[7:4];
              io_out_en <= 4'hF;
              r_cnt     <= r_cnt[0] ? 5'd0 : 5'd1;
              if (r_cnt[0])
                r_addr <= r_addr + 1'b1;
            end else begin
              io_out    <= {2'b00, w_rd_byte[w_bit_sel], 1'b0};
              io_out_en <= 4'b0010;
              r_cnt     <= r_cnt + 5'd1;
              if (r_cnt[2:0] == 3'd7) begin
                r_cnt  <= 5'd0;
                r_addr <= r_addr + 1'b1;
              end
            end
          end

          IGNORE: ;

          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/qspi_flash_model.md
QSPI_FLASH_MODEL -- requirements
Module: qspi_flash_model

Interface
REQ-001 SHALL have parameter SIZE_BYTES, default 16777216, array size in bytes, power of two, 256 to 16777216.
REQ-002 SHALL have parameter QUAD_DUMMY_CYCLES, default 4, SCLK cycles between the mode byte and data for opcode 0xEB, range 0-15.
REQ-003 SHALL have port clk_1x, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have ports flash_clk (input, 1 bit, host SCLK) and flash_csn (input, 1 bit, host chip select, active low).
REQ-006 SHALL have ports io_in (input, 4 bits, host-driven IO0-IO3) and io_in_en (input, 4 bits, host drive enables).
REQ-007 SHALL have ports io_out (output, 4 bits, model-driven IO0-IO3) and io_out_en (output, 4 bits, model drive enables).
REQ-008 SHALL have preload ports load_valid (input, 1), load_addr (input, 24), load_data (input, 8) and load_ready (output, 1).
REQ-009 SHALL have port conflict (output, 1 bit): one-cycle pulse whenever any bit of io_in_en & io_out_en is set.

Function
REQ-010 SHALL oversample flash_clk and flash_csn through a 2-flop synchroniser and detect SCLK rise/fall from synchronised samples; clk_1x is at least 4x SCLK.
REQ-011 SHALL sample io_in on a detected SCLK rise and update io_out/io_out_en on a detected SCLK fall, one clk_1x cycle after detection.
REQ-012 SHALL use FSM states IDLE, CMD, ADDR, MODE, DUMMY, DATA, IGNORE.
REQ-013 SHALL go to IDLE from any state within 1 clk_1x cycle of synchronised csn going high, with io_out_en forced to 0 in the same cycle.
REQ-014 SHALL, on csn falling, enter CMD and shift 8 bits MSB-first from io_in[0].
REQ-015 SHALL, for opcode 0x03, take 24 address bits on io_in[0] (ADDR), then DATA: one bit per SCLK MSB-first on io_out[1], io_out_en = 4'b0010.
REQ-016 SHALL, for opcode 0xEB, take address in 6 SCLKs as nibbles on io_in[3:0], then MODE (2 SCLKs, nibble-wide), then DUMMY for QUAD_DUMMY_CYCLES SCLKs, then DATA: high nibble first on io_out[3:0], io_out_en = 4'hF.
REQ-017 SHALL drive io_out_en = 0 during CMD, ADDR, MODE and DUMMY.
REQ-018 SHALL increment the byte address after each full byte in DATA and wrap modulo SIZE_BYTES; address bits above log2(SIZE_BYTES) are ignored.
REQ-019 SHALL, for opcode 0xB9, set a power-down flag at csn rise; while set, every opcode except 0xAB goes to IGNORE.
REQ-020 SHALL, for opcode 0xAB, clear the power-down flag; all other opcodes go to IGNORE (no output until csn high).
REQ-021 SHALL hold load_ready high only in IDLE with csn high, and write load_data at load_addr in any cycle with load_valid & load_ready.
REQ-022 SHALL accept a preload and an SCLK edge in the same cycle only if load_ready was high; SCLK edges are otherwise ignored in IDLE.

Reset
REQ-023 SHALL, on reset_n low, asynchronously set state = IDLE, io_out = 0, io_out_en = 0, conflict = 0, load_ready = 0, power-down flag = 0 and continuous-read flag = 0; array contents are retained.
REQ-024 SHALL raise load_ready no earlier than the second clk_1x edge after reset_n deasserts.

Configuration
REQ-025 SHALL support macro QSPI_FLASH_MODEL_CRM_EN: when defined, a 0xEB mode byte with upper nibble 0xA sets the continuous-read flag, and the next transaction skips CMD and starts in quad ADDR; any other mode byte clears the flag.
REQ-026 SHALL, without QSPI_FLASH_MODEL_CRM_EN, ignore the mode byte's value and always begin with CMD.

Structure
REQ-027 SHALL put opcode constants, the FSM state typedef and the 24-bit address width in package qspi_flash_model_pkg.
REQ-028 SHALL implement synchronisation and edge detection in sub-module qspi_sclk_sync (outputs: rise, fall, csn_sync).

Verification
REQ-029 SHALL cover SPI read: preload 0x000100=0xA5, 0x000101=0x3C; opcode 0x03 at address 0x000100 -> 16 bits 1010010100111100 on io_out[1], io_out_en=4'b0010.
REQ-030 SHALL cover quad read: 0xEB at 0x000010, mode 0x00, 4 dummies, preloaded 0x12 -> nibbles 1 then 2 on io_out, io_out_en=4'hF only in DATA.
REQ-031 SHALL cover wrap-around: SIZE_BYTES=256, read 0x0000FF for 2 bytes -> bytes [0xFF] then [0x00].
REQ-032 SHALL cover abort: csn high mid-ADDR -> io_out_en=0 within 1 cycle; the next 0x03 transaction reads correctly.
REQ-033 SHALL cover power-down: 0xB9, then 0x03 -> io_out_en stays 0; after 0xAB, 0x03 returns data.
REQ-034 SHALL cover continuous read (with QSPI_FLASH_MODEL_CRM_EN): mode 0xA0, next transaction sends address only -> correct data; mode 0xFF clears the flag.
